// File: rtl/dispatch_controller.sv
// Dispatch controller: pops one winner from the queue manager, offers it to a field
// team, escalates priority on unanswered offers, then cools down before the next start.
module dispatch_controller #(
  parameter int COOLDOWN = 2,
  parameter int TIMEOUT  = 8
) (
  input  logic       Clock,
  input  logic       Reset_Queue,
  input  logic       Enable,
  input  logic       Evac_Empty,
  input  logic       Shelter_Valid,
  input  logic       Food_Valid,
  input  logic [7:0] Output_Zone,
  input  logic [1:0] Output_Priority,
  input  logic       Team_Ready,
  output logic       Serve,
  output logic       Dispatch_Valid,
  output logic [7:0] Dispatch_Zone,
  output logic [1:0] Dispatch_Priority,
  output logic [1:0] Dispatch_Resource,
  output logic       Escalate,
  output logic       Busy,
  output logic [7:0] Evac_Count,
  output logic [7:0] Relief_Count
);
  localparam int TMAX = (TIMEOUT > COOLDOWN) ? TIMEOUT : COOLDOWN;
  localparam int TW   = $clog2(TMAX + 2);

  typedef enum logic [1:0] {IDLE, SERVE, OFFER, HOLD} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    zone_q, zone_d, evac_q, evac_d, relief_q, relief_d;
  logic [1:0]    prio_q, prio_d, res_q, res_d;
  logic          serve_q, serve_d, dv_q, dv_d, esc_q, esc_d, busy_q, busy_d;
  logic          work;

  assign work = !Evac_Empty || Shelter_Valid || Food_Valid;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    zone_d   = zone_q;
    prio_d   = prio_q;
    res_d    = res_q;
    evac_d   = evac_q;
    relief_d = relief_q;
    esc_d    = 1'b0;
    unique case (state_q)
      IDLE: if (Enable && work) begin
        state_d = SERVE;
        zone_d  = Output_Zone;
        prio_d  = Output_Priority;
        if (!Evac_Empty)                     res_d = 2'b10;
        else if (Shelter_Valid && Food_Valid) res_d = 2'b11;
        else if (Shelter_Valid)              res_d = 2'b01;
        else                                 res_d = 2'b00;
      end
      SERVE: begin
        state_d = OFFER;
        timer_d = '0;
      end
      OFFER: begin
        // An acceptance on the timeout cycle takes precedence over escalation.
        if (Team_Ready) begin
          timer_d = '0;
          state_d = (COOLDOWN == 0) ? IDLE : HOLD;
          if (res_q == 2'b10) begin
            if (evac_q != 8'hFF) evac_d = evac_q + 8'd1;
          end else begin
            if (relief_q != 8'hFF) relief_d = relief_q + 8'd1;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          esc_d   = 1'b1;
          timer_d = '0;
          if (prio_q != 2'b11) prio_d = prio_q + 2'd1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      HOLD: begin
        if (timer_q == TW'(COOLDOWN - 1)) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Status outputs are registered copies of the next state.
    serve_d = (state_d == SERVE);
    dv_d    = (state_d == OFFER);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Reset_Queue) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      zone_q   <= '0;
      prio_q   <= '0;
      res_q    <= '0;
      evac_q   <= '0;
      relief_q <= '0;
      serve_q  <= 1'b0;
      dv_q     <= 1'b0;
      esc_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      zone_q   <= zone_d;
      prio_q   <= prio_d;
      res_q    <= res_d;
      evac_q   <= evac_d;
      relief_q <= relief_d;
      serve_q  <= serve_d;
      dv_q     <= dv_d;
      esc_q    <= esc_d;
      busy_q   <= busy_d;
    end
  end

  assign Serve             = serve_q;
  assign Dispatch_Valid    = dv_q;
  assign Dispatch_Zone     = zone_q;
  assign Dispatch_Priority = prio_q;
  assign Dispatch_Resource = res_q;
  assign Escalate          = esc_q;
  assign Busy              = busy_q;
  assign Evac_Count        = evac_q;
  assign Relief_Count      = relief_q;
endmodule

// File: tb/tb_dispatch_controller.sv
// Scoreboard bench for dispatch_controller: stimulus queues expected Serve/Escalate/accept
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_dispatch_controller;
  logic       Clock = 1'b0;
  logic       Reset_Queue, Enable, Evac_Empty, Shelter_Valid, Food_Valid, Team_Ready;
  logic [7:0] Output_Zone;
  logic [1:0] Output_Priority;
  logic       Serve, Dispatch_Valid, Escalate, Busy;
  logic [7:0] Dispatch_Zone, Evac_Count, Relief_Count;
  logic [1:0] Dispatch_Priority, Dispatch_Resource;

  dispatch_controller #(.COOLDOWN(2), .TIMEOUT(8)) dut (
    .Clock(Clock), .Reset_Queue(Reset_Queue), .Enable(Enable), .Evac_Empty(Evac_Empty),
    .Shelter_Valid(Shelter_Valid), .Food_Valid(Food_Valid), .Output_Zone(Output_Zone),
    .Output_Priority(Output_Priority), .Team_Ready(Team_Ready), .Serve(Serve),
    .Dispatch_Valid(Dispatch_Valid), .Dispatch_Zone(Dispatch_Zone),
    .Dispatch_Priority(Dispatch_Priority), .Dispatch_Resource(Dispatch_Resource),
    .Escalate(Escalate), .Busy(Busy), .Evac_Count(Evac_Count), .Relief_Count(Relief_Count));

  always #5 Clock = ~Clock;

  localparam int K_SERVE = 0, K_ESC = 1, K_ACC = 2;
  typedef struct {
    int         kind;
    logic [7:0] zone;
    logic [1:0] prio;
    logic [1:0] res;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_acc  = 0;

  task automatic push(input int kind, input logic [7:0] zone, input logic [1:0] prio,
                      input logic [1:0] res);
    exp_t e;
    e.kind = kind; e.zone = zone; e.prio = prio; e.res = res;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic mon_event(input int kind);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL event: unexpected kind %0d at %0t (nothing expected)", kind, $time);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind ||
          (kind != K_SERVE && Dispatch_Priority !== e.prio) ||
          (kind == K_ACC && (Dispatch_Zone !== e.zone || Dispatch_Resource !== e.res))) begin
        errors++;
        $display("FAIL event: got kind %0d zone %0h prio %0d res %0d, expected kind %0d zone %0h prio %0d res %0d",
                 kind, Dispatch_Zone, Dispatch_Priority, Dispatch_Resource,
                 e.kind, e.zone, e.prio, e.res);
      end
    end
    if (kind == K_ACC) n_acc++;
  endtask

  always @(negedge Clock) begin
    if (Serve) mon_event(K_SERVE);
    if (Escalate) mon_event(K_ESC);
    if (Dispatch_Valid && Team_Ready && !Reset_Queue) mon_event(K_ACC);
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic clear_work();
    Evac_Empty = 1'b1; Shelter_Valid = 1'b0; Food_Valid = 1'b0;
  endtask

  initial begin
    int cyc;
    Reset_Queue = 1'b1; Enable = 1'b0; Team_Ready = 1'b0;
    Output_Zone = 8'h00; Output_Priority = 2'b00;
    clear_work();
    tick(2);
    check("reset_outputs",
          {Serve, Dispatch_Valid, Dispatch_Zone, Dispatch_Priority, Dispatch_Resource,
           Escalate, Busy, Evac_Count, Relief_Count}, 0);
    Reset_Queue = 1'b0;
    tick();

    // Evac dispatch, immediate acceptance
    push(K_SERVE, 0, 0, 0); push(K_ACC, 8'h0C, 2'b01, 2'b10);
    Evac_Empty = 1'b0; Output_Zone = 8'h0C; Output_Priority = 2'b01; Enable = 1'b1;
    tick();
    check("serve_pulse", Serve, 1);
    check("busy_serve", Busy, 1);
    clear_work();
    tick();
    check("serve_one_cycle", Serve, 0);
    check("offer_valid", Dispatch_Valid, 1);
    Team_Ready = 1'b1;
    tick();
    Team_Ready = 1'b0;
    check("dv_drop", Dispatch_Valid, 0);
    check("evac_count1", Evac_Count, 1);
    check("busy_hold", Busy, 1);
    tick();
    check("busy_hold2", Busy, 1);
    tick();
    check("busy_idle", Busy, 0);

    // Food dispatch, two timeouts with saturating escalation
    push(K_SERVE, 0, 0, 0); push(K_ESC, 0, 2'b11, 0); push(K_ESC, 0, 2'b11, 0);
    push(K_ACC, 8'h0F, 2'b11, 2'b00);
    Food_Valid = 1'b1; Output_Zone = 8'h0F; Output_Priority = 2'b10;
    tick();
    clear_work();
    tick();
    check("food_offer", Dispatch_Valid, 1);
    tick(7);
    check("no_esc_early", Escalate, 0);
    tick();
    check("esc1", Escalate, 1);
    check("esc1_prio", Dispatch_Priority, 3);
    tick();
    check("esc_pulse_one", Escalate, 0);
    tick(7);
    check("esc2", Escalate, 1);
    check("esc2_prio_sat", Dispatch_Priority, 3);
    Team_Ready = 1'b1;
    tick();
    Team_Ready = 1'b0;
    check("relief_count1", Relief_Count, 1);
    check("evac_unchanged", Evac_Count, 1);
    tick(2);

    // Mixed relief, acceptance on the timeout cycle
    push(K_SERVE, 0, 0, 0); push(K_ACC, 8'h33, 2'b00, 2'b11);
    Shelter_Valid = 1'b1; Food_Valid = 1'b1; Output_Zone = 8'h33; Output_Priority = 2'b00;
    tick();
    clear_work();
    tick(8);
    check("mixed_res", Dispatch_Resource, 2'b11);
    Team_Ready = 1'b1;
    tick();
    Team_Ready = 1'b0;
    check("race_no_esc", Escalate, 0);
    check("race_prio", Dispatch_Priority, 0);
    check("relief_count2", Relief_Count, 2);
    tick(2);

    // Enable gating and mid-dispatch drop
    Enable = 1'b0; Food_Valid = 1'b1; Output_Zone = 8'h44; Output_Priority = 2'b01;
    tick(3);
    check("disabled_busy", Busy, 0);
    check("disabled_serve", Serve, 0);
    push(K_SERVE, 0, 0, 0); push(K_ACC, 8'h44, 2'b01, 2'b00);
    Enable = 1'b1;
    tick();
    Enable = 1'b0;
    tick();
    check("drop_offer", Dispatch_Valid, 1);
    Team_Ready = 1'b1;
    tick();
    Team_Ready = 1'b0;
    tick(5);
    check("drop_done_busy", Busy, 0);
    check("relief_count3", Relief_Count, 3);
    clear_work();

    // Reset during OFFER
    push(K_SERVE, 0, 0, 0);
    Evac_Empty = 1'b0; Output_Zone = 8'h77; Enable = 1'b1;
    tick();
    clear_work();
    tick();
    check("pre_reset_offer", Dispatch_Valid, 1);
    Reset_Queue = 1'b1;
    tick();
    check("rst_dv", Dispatch_Valid, 0);
    check("rst_busy", Busy, 0);
    check("rst_counts", {Evac_Count, Relief_Count, Dispatch_Zone}, 0);
    Reset_Queue = 1'b0;
    tick();

    // 260 back-to-back evac dispatches saturate the counter
    for (int i = 0; i < 260; i++) begin
      push(K_SERVE, 0, 0, 0); push(K_ACC, 8'h55, 2'b10, 2'b10);
    end
    Evac_Empty = 1'b0; Output_Zone = 8'h55; Output_Priority = 2'b10; Enable = 1'b1;
    Team_Ready = 1'b1;
    cyc = 0;
    while (n_acc < 264 && cyc < 3000) begin
      tick();
      cyc++;
    end
    Enable = 1'b0; Team_Ready = 1'b0;
    clear_work();
    check("sat_timeout", (cyc < 3000), 1);
    tick(4);
    check("evac_sat", Evac_Count, 255);
    check("final_idle", Busy, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dispatch_controller.md
DISPATCH_CONTROLLER -- requirements
Module: dispatch_controller

Interface
REQ-001 Parameter COOLDOWN, default 2: idle cycles after each accepted dispatch.
REQ-002 Parameter TIMEOUT, default 8: OFFER cycles without Team_Ready before an escalation.
REQ-003 Clock  in  1  single clock; all state updates on rising edge.
REQ-004 Reset_Queue  in  1  synchronous, active-high reset.
REQ-005 Enable  in  1  permits new dispatch starts; gates starts only.
REQ-006 Evac_Empty  in  1  queue manager evac FIFO empty flag.
REQ-007 Shelter_Valid  in  1  queue manager shelter winner valid.
REQ-008 Food_Valid  in  1  queue manager food winner valid.
REQ-009 Output_Zone  in  8  queue manager selected zone.
REQ-010 Output_Priority  in  2  queue manager selected priority.
REQ-011 Team_Ready  in  1  field team accepts the offered dispatch.
REQ-012 Serve  out  1  one-cycle pop pulse to the queue manager.
REQ-013 Dispatch_Valid  out  1  dispatch offer to the field team.
REQ-014 Dispatch_Zone  out  8  latched zone of the current dispatch.
REQ-015 Dispatch_Priority  out  2  latched priority, escalated on timeout.
REQ-016 Dispatch_Resource  out  2  00 food, 01 shelter, 10 evac, 11 relief-mixed.
REQ-017 Escalate  out  1  one-cycle pulse on each offer timeout.
REQ-018 Busy  out  1  high in every state except IDLE.
REQ-019 Evac_Count, Relief_Count  out  8 each  accepted-dispatch counters.

Function
REQ-020 FSM states IDLE, SERVE, OFFER, HOLD; all outputs registered.
REQ-021 Work available = !Evac_Empty | Shelter_Valid | Food_Valid.
REQ-022 IDLE -> SERVE when Enable and work available; in that cycle latch Output_Zone, Output_Priority and the resource code.
REQ-023 Resource code: !Evac_Empty -> 10; else Shelter_Valid only -> 01; Food_Valid only -> 00; both -> 11.
REQ-024 SERVE: Serve high for exactly one cycle, then OFFER; Serve never high in any other state.
REQ-025 OFFER: Dispatch_Valid high; Dispatch_Zone, Dispatch_Priority and Dispatch_Resource stable while Dispatch_Valid is high, except as required by REQ-027.
REQ-026 OFFER with Team_Ready high: handshake completes that edge; Dispatch_Valid low next cycle; go to HOLD; increment Evac_Count (code 10) or Relief_Count (other codes).
REQ-027 OFFER for TIMEOUT consecutive cycles without Team_Ready: Escalate pulse, Dispatch_Priority += 1 saturating at 3, timer restarts, state stays OFFER.
REQ-028 Team_Ready in the same cycle as a timeout: handshake wins; no Escalate, no escalation.
REQ-029 HOLD lasts exactly COOLDOWN cycles, then IDLE; COOLDOWN=0 returns to IDLE the next cycle.
REQ-030 Counters saturate at 255, no wrap.
REQ-031 Enable low after IDLE does not abort: the current dispatch completes; no new start until Enable is high.
REQ-032 Team_Ready is ignored outside OFFER; queue inputs are ignored outside IDLE.
REQ-033 Dispatch latency: Serve is asserted 1 cycle after the start edge, and Dispatch_Valid 2 cycles after it.

Reset
REQ-034 Reset_Queue high: state IDLE, timers cleared, and every output 0 (Serve, Dispatch_Valid, Dispatch_Zone, Dispatch_Priority, Dispatch_Resource, Escalate, Busy, both counters) at the next edge.
REQ-035 Reset has priority over all events, including mid-OFFER and mid-HOLD; no Serve pulse or count occurs on the reset edge.

Verification
REQ-036 Evac_Empty=0, Zone=0x0C, Prio=01, Enable=1 -> Serve pulse 1 cycle, Dispatch_Valid with Zone 0x0C, Prio 01, Resource 10; Team_Ready -> Evac_Count=1; Busy low after 2 HOLD cycles.
REQ-037 Food_Valid=1 only, Zone=0x0F, Prio=10; Team_Ready held low for 8 cycles -> Escalate pulse, Prio 11; further 8 cycles -> Escalate pulse, Prio remains 11; then Team_Ready -> Relief_Count=1.
REQ-038 Shelter_Valid=Food_Valid=1, Evac_Empty=1 -> Resource 11; Team_Ready asserted on the 8th OFFER cycle -> no Escalate, Prio unchanged.
REQ-039 Work available with Enable=0 -> no Serve and Busy=0; Enable dropped during OFFER -> dispatch completes and no second Serve follows.
REQ-040 Reset_Queue asserted during OFFER -> next cycle Dispatch_Valid=0, Busy=0, counters 0; 260 accepted evac dispatches -> Evac_Count=255.
